// File: rtl/plp_id_pkg.sv
// Shared definitions for the PLP instruction-decode stage: opcode/func codes,
// writeback-source encodings, the packed control word and the main decoder.
package plp_id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] F_JALR   = 6'h09;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_LINK  = 2'd2;

    typedef struct packed {
        logic       rfw;
        logic [1:0] wbsource;
        logic       drw;
        logic [5:0] alucontrol;
        logic       j;
        logic       b;
        logic       jjr;
        logic       rfbse;
    } ctrl_t;

    localparam int CTRL_W         = $bits(ctrl_t);
    localparam int CTRL_RFW_BIT   = 13;
    localparam int CTRL_WBS_LSB   = 11;
    localparam int CTRL_DRW_BIT   = 10;
    localparam int CTRL_ALU_LSB   = 4;
    localparam int CTRL_J_BIT     = 3;
    localparam int CTRL_B_BIT     = 2;
    localparam int CTRL_JJR_BIT   = 1;
    localparam int CTRL_RFBSE_BIT = 0;

    // alucontrol carries func for R-type and the opcode otherwise, so a load
    // is recognisable downstream as alucontrol == OP_LW.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] func);
        ctrl_t c;
        c = '0;
        c.rfw = !(opcode inside {OP_BEQ, OP_BNE, OP_SW, OP_J});
        if (opcode == OP_LW)
            c.wbsource = WB_MEM;
        else if (opcode == OP_JAL || (opcode == OP_RTYPE && func == F_JALR))
            c.wbsource = WB_LINK;
        else
            c.wbsource = WB_ALU;
        c.drw        = (opcode == OP_SW);
        c.alucontrol = (opcode == OP_RTYPE) ? func : opcode;
        c.j          = (opcode inside {OP_J, OP_JAL}) ||
                       (opcode == OP_RTYPE && (func inside {F_JR, F_JALR}));
        c.b          = (opcode inside {OP_BEQ, OP_BNE});
        c.jjr        = !(opcode inside {OP_J, OP_JAL});
        c.rfbse      = (opcode != OP_RTYPE);
        return c;
    endfunction

endpackage

// File: rtl/plp_id_if.sv
// Bundle between fetch, writeback and the decode stage; the decode stage uses
// the slave modport, the surrounding pipeline (or a bench) the master modport.
interface plp_id_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    import plp_id_pkg::*;
    localparam int RAW = $clog2(NREG);

    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_inst;
    logic            ex_flush;
    logic            wb_rfw;
    logic [RAW-1:0]  wb_rf_waddr;
    logic [XLEN-1:0] wb_rf_wdata;

    logic            id_stall;
    logic            p_valid;
    logic [XLEN-1:0] p_rfa;
    logic [XLEN-1:0] p_rfb;
    logic [XLEN-1:0] p_se;
    ctrl_t           p_ctrl;
    logic [RAW-1:0]  p_rs;
    logic [RAW-1:0]  p_rt;
    logic [RAW-1:0]  p_rf_waddr;
    logic [4:0]      p_shamt;
    logic [5:0]      p_func;
    logic [25:0]     p_jaddr;
    logic [XLEN-1:0] p_pc;

    modport master (
        output if_valid, if_pc, if_inst, ex_flush, wb_rfw, wb_rf_waddr, wb_rf_wdata,
        input  id_stall, p_valid, p_rfa, p_rfb, p_se, p_ctrl, p_rs, p_rt,
               p_rf_waddr, p_shamt, p_func, p_jaddr, p_pc
    );

    modport slave (
        input  if_valid, if_pc, if_inst, ex_flush, wb_rfw, wb_rf_waddr, wb_rf_wdata,
        output id_stall, p_valid, p_rfa, p_rfb, p_se, p_ctrl, p_rs, p_rt,
               p_rf_waddr, p_shamt, p_func, p_jaddr, p_pc
    );

endinterface

// File: rtl/plp_regfile.sv
// 2R1W register file: asynchronous reads with same-cycle writeback bypass,
// posedge write, r0 hard-wired to zero. Contents are not reset.
module plp_regfile #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int RAW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [RAW-1:0]  waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RAW-1:0]  raddr [2],
    output logic [XLEN-1:0] rdata [2]
);

    logic [XLEN-1:0] mem [NREG];
    logic            wr_live;

    assign wr_live = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (wr_live)
            mem[waddr] <= wdata;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            // A write landing this edge is forwarded so ID sees the new value now.
            assign rdata[gi] = (raddr[gi] == '0)                  ? '0    :
                               (wr_live && waddr == raddr[gi])    ? wdata :
                                                                    mem[raddr[gi]];
        end
    endgenerate

endmodule

// File: rtl/plp_decode_stage.sv
// PLP instruction-decode stage: register file, main decoder and ID/EX register
// with valid bit, flush/bubble and optional load-use stall (PLP_ID_LOADUSE_STALL_EN).
module plp_decode_stage
    import plp_id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic     clk,
    input  logic     rst,
    plp_id_if.slave  bus
);

    localparam int RAW = $clog2(NREG);

    logic [5:0]      opcode;
    logic [5:0]      func;
    logic [15:0]     imm;
    logic [RAW-1:0]  rs_idx;
    logic [RAW-1:0]  rt_idx;
    logic [RAW-1:0]  rd_idx;
    logic [RAW-1:0]  raddr [2];
    logic [XLEN-1:0] rdata [2];
    logic            id_stall;
    logic            load_en;

    logic            p_valid_reg,    p_valid_next;
    logic [XLEN-1:0] p_rfa_reg,      p_rfa_next;
    logic [XLEN-1:0] p_rfb_reg,      p_rfb_next;
    logic [XLEN-1:0] p_se_reg,       p_se_next;
    ctrl_t           p_ctrl_reg,     p_ctrl_next;
    logic [RAW-1:0]  p_rs_reg,       p_rs_next;
    logic [RAW-1:0]  p_rt_reg,       p_rt_next;
    logic [RAW-1:0]  p_rf_waddr_reg, p_rf_waddr_next;
    logic [4:0]      p_shamt_reg,    p_shamt_next;
    logic [5:0]      p_func_reg,     p_func_next;
    logic [25:0]     p_jaddr_reg,    p_jaddr_next;
    logic [XLEN-1:0] p_pc_reg,       p_pc_next;

    assign opcode   = bus.if_inst[31:26];
    assign func     = bus.if_inst[5:0];
    assign imm      = bus.if_inst[15:0];
    assign rs_idx   = bus.if_inst[21 +: RAW];
    assign rt_idx   = bus.if_inst[16 +: RAW];
    assign rd_idx   = bus.if_inst[11 +: RAW];
    assign raddr[0] = rs_idx;
    assign raddr[1] = rt_idx;

    plp_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk   (clk),
        .we    (bus.wb_rfw),
        .waddr (bus.wb_rf_waddr),
        .wdata (bus.wb_rf_wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

`ifdef PLP_ID_LOADUSE_STALL_EN
    // The load in EX cannot forward in time; the bubble this inserts clears
    // p_valid, so the stall lasts exactly one cycle.
    assign id_stall = bus.if_valid & p_valid_reg & (p_ctrl_reg.alucontrol == OP_LW) &
                      (p_rf_waddr_reg != '0) &
                      ((p_rf_waddr_reg == rs_idx) | (p_rf_waddr_reg == rt_idx));
`else
    assign id_stall = 1'b0;
`endif

    assign load_en = bus.if_valid && !bus.ex_flush && !id_stall;

    always_comb begin
        p_valid_next    = 1'b0;
        p_rfa_next      = '0;
        p_rfb_next      = '0;
        p_se_next       = '0;
        p_ctrl_next     = '0;
        p_rs_next       = '0;
        p_rt_next       = '0;
        p_rf_waddr_next = '0;
        p_shamt_next    = '0;
        p_func_next     = '0;
        p_jaddr_next    = '0;
        p_pc_next       = '0;
        if (load_en) begin
            p_valid_next    = 1'b1;
            p_rfa_next      = rdata[0];
            p_rfb_next      = rdata[1];
            p_se_next       = (opcode == OP_ANDI || opcode == OP_ORI) ? XLEN'(imm)
                                                                      : XLEN'($signed(imm));
            p_ctrl_next     = decode_ctrl(opcode, func);
            p_rs_next       = rs_idx;
            p_rt_next       = rt_idx;
            if (opcode == OP_RTYPE)
                p_rf_waddr_next = rd_idx;
            else if (opcode == OP_JAL)
                p_rf_waddr_next = RAW'(NREG - 1);
            else
                p_rf_waddr_next = rt_idx;
            p_shamt_next    = bus.if_inst[10:6];
            p_func_next     = func;
            p_jaddr_next    = bus.if_inst[25:0];
            p_pc_next       = bus.if_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_reg    <= 1'b0;
            p_rfa_reg      <= '0;
            p_rfb_reg      <= '0;
            p_se_reg       <= '0;
            p_ctrl_reg     <= '0;
            p_rs_reg       <= '0;
            p_rt_reg       <= '0;
            p_rf_waddr_reg <= '0;
            p_shamt_reg    <= '0;
            p_func_reg     <= '0;
            p_jaddr_reg    <= '0;
            p_pc_reg       <= '0;
        end else begin
            p_valid_reg    <= p_valid_next;
            p_rfa_reg      <= p_rfa_next;
            p_rfb_reg      <= p_rfb_next;
            p_se_reg       <= p_se_next;
            p_ctrl_reg     <= p_ctrl_next;
            p_rs_reg       <= p_rs_next;
            p_rt_reg       <= p_rt_next;
            p_rf_waddr_reg <= p_rf_waddr_next;
            p_shamt_reg    <= p_shamt_next;
            p_func_reg     <= p_func_next;
            p_jaddr_reg    <= p_jaddr_next;
            p_pc_reg       <= p_pc_next;
        end
    end

    assign bus.id_stall   = id_stall;
    assign bus.p_valid    = p_valid_reg;
    assign bus.p_rfa      = p_rfa_reg;
    assign bus.p_rfb      = p_rfb_reg;
    assign bus.p_se       = p_se_reg;
    assign bus.p_ctrl     = p_ctrl_reg;
    assign bus.p_rs       = p_rs_reg;
    assign bus.p_rt       = p_rt_reg;
    assign bus.p_rf_waddr = p_rf_waddr_reg;
    assign bus.p_shamt    = p_shamt_reg;
    assign bus.p_func     = p_func_reg;
    assign bus.p_jaddr    = p_jaddr_reg;
    assign bus.p_pc       = p_pc_reg;

endmodule
